sram_arbiter: RTL and testbench

Shares one single-ported synchronous SRAM (`sram_wrapper` interface: active-low cs/we/byte-enables, 1-cycle read latency) between NPORTS requesters, such as CPU, DMA and display fetch.
- Priority is fixed, lowest index first, with an aging override so low-priority ports cannot starve.
- At most one access is issued per cycle, and a new access may issue every cycle.
- Read data is returned with a per-port one-cycle-delayed valid strobe.

---
 rtl/sram_arbiter.sv | 88 ++++++++
 tb/tb_sram_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - fixed-priority SRAM arbiter with aging override
// Shares one single-ported synchronous SRAM among NPORTS requesters; reads return one cycle after grant.
module sram_arbiter #(
  parameter int NPORTS   = 2,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 512,
  parameter int MAX_WAIT = 7,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     req,
  input  logic [NPORTS-1:0]     we,
  input  logic [NPORTS*BW-1:0]  be,
  input  logic [NPORTS*AW-1:0]  addr,
  input  logic [NPORTS*WIDTH-1:0] wdata,
  output logic [NPORTS-1:0]     gnt,
  output logic [NPORTS-1:0]     rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  sram_cs_n,
  output logic                  sram_we_n,
  output logic [BW-1:0]         sram_be_n,
  output logic [AW-1:0]         sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  input  logic [WIDTH-1:0]      sram_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt [NPORTS];
  logic [NPORTS-1:0] rd_owner;
  logic [NPORTS-1:0] urgent;
  logic [IW-1:0]     win;
  logic              any_gnt;

  // Descending loops so the lowest matching index is assigned last and wins;
  // the urgent pass runs second so it overrides plain priority.
  always_comb begin
    win = '0;
    for (int i = 0; i < NPORTS; i++) begin
      urgent[i] = req[i] && (wait_cnt[i] == MAXW);
    end
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
    if (|urgent) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (urgent[i]) win = IW'(i);
      end
    end
  end

  always_comb begin
    any_gnt = (|req) && !rst;
    gnt = '0;
    if (any_gnt) gnt[win] = 1'b1;
  end

  always_comb begin
    sram_cs_n  = !any_gnt;
    sram_we_n  = any_gnt ? !we[win] : 1'b1;
    sram_be_n  = (any_gnt && we[win]) ? ~be[win*BW +: BW] : '1;
    sram_addr  = addr[win*AW +: AW];
    sram_wdata = wdata[win*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= '0;
      for (int i = 0; i < NPORTS; i++) wait_cnt[i] <= '0;
    end else begin
      rd_owner <= gnt & ~we;
      for (int i = 0; i < NPORTS; i++) begin
        if (!req[i] || gnt[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != MAXW)
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  // A read granted just before reset still has its owner bit set during rst; mask it.
  assign rvalid = rst ? '0 : rd_owner;
  assign rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
// Contains a behavioural 1-cycle-latency SRAM with active-low controls.
module tb_sram_arbiter;
  localparam int NP = 2, W = 32, D = 512, AW = 9, BW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req, we, gnt, rvalid;
  logic [NP*BW-1:0] be;
  logic [NP*AW-1:0] addr;
  logic [NP*W-1:0] wdata;
  logic [W-1:0] rdata, sram_wdata, sram_rdata;
  logic sram_cs_n, sram_we_n;
  logic [BW-1:0] sram_be_n;
  logic [AW-1:0] sram_addr;
  logic [W-1:0] mem [D];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.NPORTS(NP), .WIDTH(W), .DEPTH(D), .MAX_WAIT(7)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int b = 0; b < BW; b++)
          if (!sram_be_n[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic w, input logic [BW-1:0] b,
                          input logic [AW-1:0] a, input logic [W-1:0] d);
    req[p] = r;
    we[p] = w;
    be[p*BW +: BW] = b;
    addr[p*AW +: AW] = a;
    wdata[p*W +: W] = d;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt c%0d got %b want 00", c, gnt); end
      if (rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid c%0d got %b want 00", c, rvalid); end
      if (sram_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n c%0d got %b want 1", c, sram_cs_n); end
      if (sram_be_n !== 4'hF) begin n_bad++; $display("FAIL reset_be_n c%0d got %b want 1111", c, sram_be_n); end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 4'h0, 9'h1A5, 32'h0);
    #1;
    n_cmp += 4;
    if (gnt !== 2'b10) begin n_bad++; $display("FAIL rd_gnt got %b want 10", gnt); end
    if (sram_addr !== 9'h1A5) begin n_bad++; $display("FAIL rd_addr got %h want 1a5", sram_addr); end
    if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL rd_we_n got %b want 1", sram_we_n); end
    if (sram_cs_n !== 1'b0) begin n_bad++; $display("FAIL rd_cs_n got %b want 0", sram_cs_n); end
    @(negedge clk);
    req = '0;
    n_cmp += 2;
    if (rvalid !== 2'b10) begin n_bad++; $display("FAIL rd_rvalid got %b want 10", rvalid); end
    if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata got %h want deadbeef", rdata); end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 4'b0100, 9'h010, 32'h00AB0000);
    #1;
    n_cmp += 3;
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL wr_gnt got %b want 01", gnt); end
    if (sram_be_n !== 4'b1011) begin n_bad++; $display("FAIL wr_be_n got %b want 1011", sram_be_n); end
    if (sram_we_n !== 1'b0) begin n_bad++; $display("FAIL wr_we_n got %b want 0", sram_we_n); end
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 4'b1111, 9'h010, 32'h0);
    #1;
    n_cmp += 3;
    if (rvalid !== 2'b00) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 00", rvalid); end
    if (sram_be_n !== 4'b1111) begin n_bad++; $display("FAIL rdbk_be_n got %b want 1111", sram_be_n); end
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL rdbk_gnt got %b want 01", gnt); end
    @(negedge clk);
    req = '0;
    n_cmp += 2;
    if (rvalid !== 2'b01) begin n_bad++; $display("FAIL rdbk_rvalid got %b want 01", rvalid); end
    if (rdata !== 32'h11AB3344) begin n_bad++; $display("FAIL rdbk_rdata got %h want 11ab3344", rdata); end
  endtask

  task automatic test_aging();
    logic [1:0] exp;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 4'h0, 9'h001, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 9'h002, 32'h0);
    for (int c = 0; c < 17; c++) begin
      #1;
      exp = (c % 8 == 7) ? 2'b10 : 2'b01;
      n_cmp++;
      if (gnt !== exp) begin n_bad++; $display("FAIL aging_gnt c%0d got %b want %b", c, gnt, exp); end
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg [4];
    logic [1:0] ev [4];
    logic [W-1:0] ed [4];
    eg = '{2'b01, 2'b01, 2'b10, 2'b00};
    ev = '{2'b00, 2'b01, 2'b01, 2'b10};
    ed = '{32'h0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hB0B0B0B0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = '0;
      if (c == 0) set_port(0, 1'b1, 1'b0, 4'h0, 9'h020, 32'h0);
      if (c == 1) set_port(0, 1'b1, 1'b0, 4'h0, 9'h021, 32'h0);
      if (c == 2) set_port(1, 1'b1, 1'b0, 4'h0, 9'h1F0, 32'h0);
      #1;
      n_cmp += 2;
      if (gnt !== eg[c]) begin n_bad++; $display("FAIL b2b_gnt c%0d got %b want %b", c, gnt, eg[c]); end
      if (rvalid !== ev[c]) begin n_bad++; $display("FAIL b2b_rvalid c%0d got %b want %b", c, rvalid, ev[c]); end
      if (c > 0) begin
        n_cmp++;
        if (rdata !== ed[c]) begin n_bad++; $display("FAIL b2b_rdata c%0d got %h want %h", c, rdata, ed[c]); end
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] exp;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 4'h0, 9'h020, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 9'h021, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 2'b01) begin n_bad++; $display("FAIL pre_rst_gnt c%0d got %b want 01", c, gnt); end
      @(negedge clk);
    end
    rst = 1'b1;
    req = '0;
    #1;
    n_cmp += 2;
    if (rvalid !== 2'b00) begin n_bad++; $display("FAIL mid_rst_rvalid got %b want 00", rvalid); end
    if (sram_cs_n !== 1'b1) begin n_bad++; $display("FAIL mid_rst_cs_n got %b want 1", sram_cs_n); end
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp = (c == 7) ? 2'b10 : 2'b01;
      n_cmp++;
      if (gnt !== exp) begin n_bad++; $display("FAIL post_rst_gnt c%0d got %b want %b", c, gnt, exp); end
      @(negedge clk);
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 32'h0;
    mem[9'h1A5] = 32'hDEADBEEF;
    mem[9'h010] = 32'h11223344;
    mem[9'h020] = 32'hA0A0A0A0;
    mem[9'h021] = 32'hA1A1A1A1;
    mem[9'h1F0] = 32'hB0B0B0B0;
    sram_rdata = '0;
    rst = 1'b1;
    req = 2'b11;
    we = '0;
    be = '0;
    addr = '0;
    wdata = '0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_aging();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
